// File: rtl/hssl_pkg.sv
// hssl_pkg: shared definitions for the HSSL packet receive front-end.
//   - Packet field offsets and widths (header, key, payload).
//   - Header bit positions for payload-present and parity.
//   - Receive state type (run / flush / stop).
//   - Diagnostic counter-pulse bit indices.
package hssl_pkg;

    localparam int unsigned PKT_W   = 72;

    localparam int unsigned HDR_LSB = 0;
    localparam int unsigned HDR_W   = 8;
    localparam int unsigned KEY_LSB = 8;
    localparam int unsigned KEY_W   = 32;
    localparam int unsigned PL_LSB  = 40;
    localparam int unsigned PL_W    = 32;

    // The low key byte is the register word address; the rest is the cfg prefix.
    localparam int unsigned KEY_ADDR_W   = 8;
    localparam int unsigned KEY_PREFIX_W = KEY_W - KEY_ADDR_W;

    localparam int unsigned HDR_PAR_BIT = 0;
    localparam int unsigned HDR_PL_BIT  = 1;

    localparam int unsigned CTR_DROP = 0;
    localparam int unsigned CTR_CFG  = 1;

    typedef enum logic [1:0] {
        StRun   = 2'd0,
        StFlush = 2'd1,
        StStop  = 2'd2
    } state_e;

endpackage

// File: rtl/hssl_pkt_buf.sv
// hssl_pkt_buf: one-entry registered output buffer with valid/ready handshake.
//   clk       in   clock
//   reset     in   synchronous active-high reset
//   load_in   in   capture load_data_in (caller only loads when the slot is free or draining)
//   load_data_in in WIDTH bits to capture
//   rdy_in    in   downstream ready; empties the slot when no new load arrives
//   vld_out   out  slot holds a packet
//   data_out  out  buffered packet, zero when empty
module hssl_pkt_buf
    import hssl_pkg::*;
#(
    parameter int unsigned WIDTH = PKT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_in,
    input  logic [WIDTH-1:0] load_data_in,
    input  logic             rdy_in,
    output logic             vld_out,
    output logic [WIDTH-1:0] data_out
);

    logic             vld_q, vld_d;
    logic [WIDTH-1:0] data_q, data_d;

    always_comb begin
        vld_d  = vld_q;
        data_d = data_q;
        if (load_in) begin
            // A load during a dequeue replaces the old entry; valid stays high.
            vld_d  = 1'b1;
            data_d = load_data_in;
        end else if (rdy_in) begin
            vld_d  = 1'b0;
            data_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q  <= 1'b0;
            data_q <= '0;
        end else begin
            vld_q  <= vld_d;
            data_q <= data_d;
        end
    end

    assign vld_out  = vld_q;
    assign data_out = data_q;

endmodule

// File: rtl/hssl_pkt_cfg_rx.sv
// hssl_pkt_cfg_rx: HSSL receive packet front-end.
// Parity-checks and classifies each accepted packet. Configuration packets become
// one-cycle register-write strobes (prx_*); data packets go to a one-entry output
// buffer in run state and are discarded while flushing/stopped. Emits per-packet
// diagnostic counter pulses.
//   clk, reset              single clock, synchronous active-high reset
//   pkt_data_in/vld_in/rdy_out  input packet handshake
//   pkt_data_out/vld_out/rdy_in forwarded packet handshake
//   prx_addr_out/data_out/vld_out register-write port toward the bank
//   hssl_stop_in            stop request
//   ctr_cnt_out             count pulses: bit CTR_DROP = drop, bit CTR_CFG = cfg write
// Build option: define HSSL_PRX_PARITY_CHECK_EN to enable the odd-parity check;
// otherwise every packet is treated as parity-correct.
module hssl_pkt_cfg_rx
    import hssl_pkg::*;
#(
    parameter logic [KEY_PREFIX_W-1:0] CFG_KEY_PREFIX = 24'hFFFE00,
    parameter int unsigned             NUM_CREGS      = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [PKT_W-1:0]      pkt_data_in,
    input  logic                  pkt_vld_in,
    output logic                  pkt_rdy_out,
    output logic [PKT_W-1:0]      pkt_data_out,
    output logic                  pkt_vld_out,
    input  logic                  pkt_rdy_in,
    output logic [KEY_ADDR_W-1:0] prx_addr_out,
    output logic [PL_W-1:0]       prx_data_out,
    output logic                  prx_vld_out,
    input  logic                  hssl_stop_in,
    output logic [NUM_CREGS-1:0]  ctr_cnt_out
);

    state_e state_q, state_d;

    logic [HDR_W-1:0] hdr;
    logic [KEY_W-1:0] key;
    logic [PL_W-1:0]  payload;
    logic             transfer;
    logic             par_ok;
    logic             key_match;
    logic             is_cfg, is_fwd, is_drop;

    logic                  prx_vld_q;
    logic [KEY_ADDR_W-1:0] prx_addr_q;
    logic [PL_W-1:0]       prx_data_q;
    logic [NUM_CREGS-1:0]  ctr_q, ctr_d;

    assign hdr     = pkt_data_in[HDR_LSB +: HDR_W];
    assign key     = pkt_data_in[KEY_LSB +: KEY_W];
    assign payload = pkt_data_in[PL_LSB +: PL_W];

    assign transfer  = pkt_vld_in && pkt_rdy_out;
    assign key_match = (key[KEY_W-1:KEY_ADDR_W] == CFG_KEY_PREFIX);

`ifdef HSSL_PRX_PARITY_CHECK_EN
    // Odd parity over the whole packet, parity bit included.
    assign par_ok = ^pkt_data_in;
`else
    assign par_ok = 1'b1;
`endif

    // Priority: parity error, cfg write, prefix without payload, data.
    always_comb begin
        is_cfg  = 1'b0;
        is_fwd  = 1'b0;
        is_drop = 1'b0;
        if (transfer) begin
            if (!par_ok) begin
                is_drop = 1'b1;
            end else if (key_match && hdr[HDR_PL_BIT]) begin
                is_cfg = 1'b1;
            end else if (key_match) begin
                is_drop = 1'b1;
            end else if (state_q == StRun) begin
                is_fwd = 1'b1;
            end else begin
                is_drop = 1'b1;
            end
        end
    end

    // Outside run, always accept so a cfg packet can still get through and clear stop.
    always_comb begin
        pkt_rdy_out = 1'b0;
        if (!reset) begin
            if (state_q == StRun) begin
                pkt_rdy_out = !pkt_vld_out || pkt_rdy_in;
            end else begin
                pkt_rdy_out = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StRun: begin
                if (hssl_stop_in) state_d = StFlush;
            end
            StFlush: begin
                if (!hssl_stop_in) begin
                    state_d = StRun;
                end else if (!pkt_vld_out) begin
                    state_d = StStop;
                end
            end
            StStop: begin
                if (!hssl_stop_in) state_d = StRun;
            end
            default: state_d = StRun;
        endcase
    end

    always_comb begin
        ctr_d = '0;
        for (int unsigned i = 0; i < NUM_CREGS; i++) begin
            ctr_d[i] = ((i == CTR_DROP) && is_drop) || ((i == CTR_CFG) && is_cfg);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StRun;
            prx_vld_q  <= 1'b0;
            prx_addr_q <= '0;
            prx_data_q <= '0;
            ctr_q      <= '0;
        end else begin
            state_q   <= state_d;
            prx_vld_q <= is_cfg;
            ctr_q     <= ctr_d;
            if (is_cfg) begin
                prx_addr_q <= key[KEY_ADDR_W-1:0];
                prx_data_q <= payload;
            end
        end
    end

    hssl_pkt_buf #(
        .WIDTH (PKT_W)
    ) u_buf (
        .clk          (clk),
        .reset        (reset),
        .load_in      (is_fwd),
        .load_data_in (pkt_data_in),
        .rdy_in       (pkt_rdy_in),
        .vld_out      (pkt_vld_out),
        .data_out     (pkt_data_out)
    );

    assign prx_vld_out  = prx_vld_q;
    assign prx_addr_out = prx_addr_q;
    assign prx_data_out = prx_data_q;
    assign ctr_cnt_out  = ctr_q;

endmodule

// File: tb/tb_hssl_pkt_cfg_rx.sv
module tb_hssl_pkt_cfg_rx;
    import hssl_pkg::*;

    typedef enum int {EXP_FWD, EXP_CFG, EXP_DROP, EXP_HOLD} exp_e;

    logic        clk = 1'b0;
    logic        reset;
    logic [71:0] pkt_data_in;
    logic        pkt_vld_in;
    logic        pkt_rdy_out;
    logic [71:0] pkt_data_out;
    logic        pkt_vld_out;
    logic        pkt_rdy_in;
    logic [7:0]  prx_addr_out;
    logic [31:0] prx_data_out;
    logic        prx_vld_out;
    logic        hssl_stop_in;
    logic [1:0]  ctr_cnt_out;

    int errors = 0;
    int checks = 0;

    logic [71:0] q_fwd[$];
    logic [39:0] q_prx[$];
    logic [1:0]  q_ctr[$];

    logic        hold_prev = 1'b0;
    logic [71:0] hold_data = '0;

    hssl_pkt_cfg_rx dut (
        .clk          (clk),
        .reset        (reset),
        .pkt_data_in  (pkt_data_in),
        .pkt_vld_in   (pkt_vld_in),
        .pkt_rdy_out  (pkt_rdy_out),
        .pkt_data_out (pkt_data_out),
        .pkt_vld_out  (pkt_vld_out),
        .pkt_rdy_in   (pkt_rdy_in),
        .prx_addr_out (prx_addr_out),
        .prx_data_out (prx_data_out),
        .prx_vld_out  (prx_vld_out),
        .hssl_stop_in (hssl_stop_in),
        .ctr_cnt_out  (ctr_cnt_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input logic [71:0] act);
        checks++;
        errors++;
        $display("FAIL %s: got %h, expected nothing", name, act);
    endtask

    // Header: bit1 payload present, bit0 chosen so the 72-bit xor is 1.
    function automatic logic [71:0] mk(input logic [31:0] k, input logic [31:0] pl,
                                       input logic has_pl);
        logic [71:0] p;
        p = {pl, k, 6'b0, has_pl, 1'b0};
        if (^p == 1'b0) p[0] = 1'b1;
        return p;
    endfunction

    // Monitor: pops the scoreboard whenever the DUT presents an output.
    always @(negedge clk) begin
        if (reset) begin
            hold_prev <= 1'b0;
        end else begin
            if (hold_prev) begin
                chk("hold_vld", {71'b0, pkt_vld_out}, 72'd1);
                chk("hold_data", pkt_data_out, hold_data);
            end
            if (pkt_vld_out && pkt_rdy_in) begin
                if (q_fwd.size() == 0) unexpected("fwd_data", pkt_data_out);
                else chk("fwd_data", pkt_data_out, q_fwd.pop_front());
            end
            if (prx_vld_out) begin
                if (q_prx.size() == 0) unexpected("prx_write", {32'b0, prx_addr_out, prx_data_out});
                else chk("prx_write", {32'b0, prx_addr_out, prx_data_out},
                         {32'b0, q_prx.pop_front()});
            end
            if (ctr_cnt_out != 2'b00) begin
                if (q_ctr.size() == 0) unexpected("ctr_pulse", {70'b0, ctr_cnt_out});
                else chk("ctr_pulse", {70'b0, ctr_cnt_out}, {70'b0, q_ctr.pop_front()});
            end
            hold_prev <= pkt_vld_out && !pkt_rdy_in;
            hold_data <= pkt_data_out;
        end
    end

    // Offer a packet, wait (bounded) for acceptance, push expectations, check latency.
    task automatic send(input logic [71:0] p, input exp_e e, output int waits);
        pkt_data_in = p;
        pkt_vld_in  = 1'b1;
        waits       = 0;
        do begin
            @(negedge clk);
            waits++;
        end while (!pkt_rdy_out && waits < 20);
        if (!pkt_rdy_out) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: pkt %h not accepted after %0d cycles", p, waits);
            pkt_vld_in = 1'b0;
            return;
        end
        case (e)
            EXP_FWD:  q_fwd.push_back(p);
            EXP_CFG:  begin
                q_prx.push_back({p[15:8], p[71:40]});
                q_ctr.push_back(2'b10);
            end
            EXP_DROP: q_ctr.push_back(2'b01);
            default:  ;
        endcase
        @(posedge clk);
        #1;
        case (e)
            EXP_FWD, EXP_HOLD: begin
                chk("lat_fwd_vld", {71'b0, pkt_vld_out}, 72'd1);
                chk("lat_fwd_data", pkt_data_out, p);
            end
            EXP_CFG:  chk("lat_cfg", {69'b0, prx_vld_out, ctr_cnt_out}, 72'b110);
            default:  chk("lat_drop", {69'b0, prx_vld_out, ctr_cnt_out}, 72'b001);
        endcase
    endtask

    task automatic idle(input int n);
        pkt_vld_in = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (20000) @(posedge clk);
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [71:0] pa, pb, pc, pcfg;
        int w;

        reset        = 1'b1;
        pkt_data_in  = '0;
        pkt_vld_in   = 1'b0;
        pkt_rdy_in   = 1'b1;
        hssl_stop_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rdy_out", {71'b0, pkt_rdy_out}, 72'd0);
        chk("rst_outs", {pkt_vld_out, prx_vld_out, prx_addr_out, prx_data_out, ctr_cnt_out},
            72'd0);
        chk("rst_data_out", pkt_data_out, 72'd0);
        chk("rst_state", {70'b0, dut.state_q}, {70'b0, StRun});
        reset = 1'b0;
        #1;
        chk("run_rdy_out", {71'b0, pkt_rdy_out}, 72'd1);

        // Plain data packet.
        pa = mk(32'h1234_5678, 32'hA5A5_0001, 1'b1);
        send(pa, EXP_FWD, w);
        idle(2);

        // Configuration write.
        pcfg = mk(32'hFFFE_0010, 32'hCAFE_F00D, 1'b1);
        send(pcfg, EXP_CFG, w);
        idle(1);
        chk("cfg_addr_hold", {32'b0, prx_addr_out, prx_data_out}, {32'b0, 8'h10, 32'hCAFE_F00D});

        // Prefix match without payload is dropped.
        send(mk(32'hFFFE_0033, 32'h0, 1'b0), EXP_DROP, w);
        idle(2);

        // Full throughput: back-to-back accepts, valid stays high across replace.
        for (int i = 0; i < 3; i++) begin
            send(mk(32'h0000_1000 + i, 32'h5000_0000 + i, 1'b1), EXP_FWD, w);
            chk("throughput_wait", w, 1);
        end
        idle(2);

        // Parity bit flipped.
        pb = mk(32'h1234_5678, 32'h0BAD_0BAD, 1'b1);
        pb[0] = ~pb[0];
`ifdef HSSL_PRX_PARITY_CHECK_EN
        send(pb, EXP_DROP, w);
`else
        send(pb, EXP_FWD, w);
`endif
        idle(2);

        // Back-pressure.
        pkt_rdy_in = 1'b0;
        pa = mk(32'h0000_AAAA, 32'h1111_1111, 1'b1);
        pb = mk(32'h0000_BBBB, 32'h2222_2222, 1'b1);
        send(pa, EXP_FWD, w);
        pkt_data_in = pb;
        pkt_vld_in  = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("bp_rdy_out", {71'b0, pkt_rdy_out}, 72'd0);
        end
        @(posedge clk);
        #1;
        pkt_rdy_in = 1'b1;
        send(pb, EXP_FWD, w);
        chk("bp_accept_wait", w, 1);
        idle(2);

        // Stop sequence.
        pkt_rdy_in = 1'b0;
        pc = mk(32'h0000_CCCC, 32'h3333_3333, 1'b1);
        send(pc, EXP_FWD, w);
        idle(1);
        hssl_stop_in = 1'b1;
        idle(3);
        chk("flush_state", {70'b0, dut.state_q}, {70'b0, StFlush});
        chk("flush_rdy_out", {71'b0, pkt_rdy_out}, 72'd1);
        pkt_rdy_in = 1'b1;
        idle(3);
        chk("stop_state", {70'b0, dut.state_q}, {70'b0, StStop});
        pkt_rdy_in = 1'b0;
        send(mk(32'h0000_DDDD, 32'h4444_4444, 1'b1), EXP_DROP, w);
        send(mk(32'hFFFE_0022, 32'h1357_9BDF, 1'b1), EXP_CFG, w);
        idle(1);
        hssl_stop_in = 1'b0;
        idle(1);
        chk("resume_state", {70'b0, dut.state_q}, {70'b0, StRun});
        pkt_rdy_in = 1'b1;
        idle(1);

        // Stop rising with a transfer: packet still classified under run.
        hssl_stop_in = 1'b1;
        send(mk(32'h0000_EEEE, 32'h5555_5555, 1'b1), EXP_FWD, w);
        idle(3);
        chk("stop2_state", {70'b0, dut.state_q}, {70'b0, StStop});
        hssl_stop_in = 1'b0;
        idle(2);

        // Reset with a packet buffered.
        pkt_rdy_in = 1'b0;
        send(mk(32'h0000_FFFF, 32'h6666_6666, 1'b1), EXP_HOLD, w);
        pkt_vld_in = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        chk("rst2_rdy_out", {71'b0, pkt_rdy_out}, 72'd0);
        @(posedge clk);
        #1;
        chk("rst2_outs", {pkt_vld_out, prx_vld_out, prx_addr_out, prx_data_out, ctr_cnt_out},
            72'd0);
        chk("rst2_data_out", pkt_data_out, 72'd0);
        chk("rst2_state", {70'b0, dut.state_q}, {70'b0, StRun});
        reset      = 1'b0;
        pkt_rdy_in = 1'b1;
        idle(4);

        chk("fwd_q_empty", q_fwd.size(), 72'd0);
        chk("prx_q_empty", q_prx.size(), 72'd0);
        chk("ctr_q_empty", q_ctr.size(), 72'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hssl_pkt_cfg_rx.md
# hssl_pkt_cfg_rx

Packet front-end between the HSSL receive path and the register bank / input router. Each incoming SpiNNaker packet is parity-checked and classified. Configuration packets become single-cycle register-write strobes on the bank's packet-write port (`prx_*`). All other packets go through a one-entry registered output buffer with valid/ready handshake. The block also generates the per-cycle count pulses for the bank's diagnostic counters and honours the HSSL stop control.

## Interface
Parameters:
- `CFG_KEY_PREFIX`, default 24'hFFFE_00: `key[31:8]` value that identifies a configuration packet.
- `NUM_CREGS`, default 2: width of the counter-pulse output.

Ports:
- `clk`  in  1  single clock.
- `reset`  in  1  synchronous, active-high reset.
- `pkt_data_in`  in  72  packet; `[7:0]` header, `[39:8]` key, `[71:40]` payload.
- `pkt_vld_in`  in  1  input packet valid.
- `pkt_rdy_out`  out  1  input ready.
- `pkt_data_out`  out  72  forwarded packet.
- `pkt_vld_out`  out  1  forwarded packet valid.
- `pkt_rdy_in`  in  1  downstream ready.
- `prx_addr_out`  out  8  register word address (`key[7:0]`).
- `prx_data_out`  out  32  register data (payload).
- `prx_vld_out`  out  1  register-write strobe, one cycle per configuration packet.
- `hssl_stop_in`  in  1  stop request from the register bank.
- `ctr_cnt_out`  out  NUM_CREGS  count pulses; bit0 = dropped packet, bit1 = configuration write.

## Operation
- Transfer happens on `pkt_vld_in && pkt_rdy_out`.
- Header bit1 set = payload present. Header bit0 = parity bit; odd parity over all 72 bits is required.
- Classification of each accepted packet, in priority order:
  1. Parity error: drop, pulse `ctr_cnt_out[0]`.
  2. Configuration packet (`key[31:8]==CFG_KEY_PREFIX` and payload present): pulse `prx_vld_out`, pulse `ctr_cnt_out[1]`.
  3. Key matches the prefix but no payload: drop, pulse `ctr_cnt_out[0]`.
  4. Otherwise, data packet: forward in state RUN; drop and pulse `ctr_cnt_out[0]` in states FLUSH and STOP.
- Configuration writes are never stalled; the bank gives packet writes priority.
- State machine:
  - RUN to FLUSH when `hssl_stop_in==1`.
  - FLUSH to STOP when the output buffer is empty (`pkt_vld_out==0`).
  - STOP to RUN when `hssl_stop_in==0`.
  - FLUSH to RUN when `hssl_stop_in==0` before the buffer drains.
  - No input packets are forwarded in FLUSH or STOP; the buffered packet still drains in FLUSH.
- Input ready:
  - In RUN, `pkt_rdy_out = !pkt_vld_out || pkt_rdy_in` (combinational).
  - In FLUSH and STOP, `pkt_rdy_out = 1`. Traffic is discarded so a configuration packet can still clear stop.
- Output buffer: loaded on a forward. Held stable while `pkt_vld_out && !pkt_rdy_in`. Cleared on `pkt_rdy_in` with no new load.

## Timing
- Reset values: `pkt_vld_out=0`, `pkt_data_out=0`, `prx_vld_out=0`, `prx_addr_out=0`, `prx_data_out=0`, `ctr_cnt_out=0`, state RUN.
- `pkt_rdy_out` during reset is 0.
- Latency, transfer to `pkt_vld_out`: 1 cycle.
- Latency, transfer to `prx_vld_out` and `ctr_cnt_out` pulses: 1 cycle.
- All pulses are exactly one cycle wide.
- Full throughput: one packet per cycle when `pkt_rdy_in` is held high.
- Simultaneous output dequeue and load: the new packet replaces the old one with `pkt_vld_out` staying high.
- `prx_addr_out`/`prx_data_out` hold their last value when `prx_vld_out=0`.
- `hssl_stop_in` rising in the same cycle as a transfer: that packet is still classified under RUN.
- Reset asserted mid-operation: the buffered packet is discarded, no pulses are emitted, and the block restarts in RUN.

## Configuration
- `HSSL_PRX_PARITY_CHECK_EN` defined: parity is checked as described above.
- Not defined: the parity check logic is compiled out, every packet is treated as parity-correct, and parity never causes a drop.

## Structure
- Shared package `hssl_pkg` holds:
  - The packet field offsets and widths (header, key, payload).
  - The header bit positions for payload-present and parity.
  - The state typedef (RUN, FLUSH, STOP).
  - The counter-bit indices (`CTR_DROP=0`, `CTR_CFG=1`).
- One sub-module, `hssl_pkt_buf`: the one-entry valid/ready output register.

## Test plan
- Data packet with key 0x1234_5678, correct parity, `pkt_rdy_in=1`: appears on `pkt_data_out` one cycle later; no `prx_vld_out`.
- Configuration packet with key 0xFFFE_0010, payload 0xCAFE_F00D: `prx_vld_out` pulses one cycle later with `prx_addr_out=0x10`, `prx_data_out=0xCAFE_F00D`; `ctr_cnt_out[1]` pulses.
- Back-pressure: `pkt_rdy_in=0` with two data packets offered: first is held stable, `pkt_rdy_out=0`; second is accepted the cycle after `pkt_rdy_in` rises.
- With `HSSL_PRX_PARITY_CHECK_EN`, one parity bit flipped: packet dropped and `ctr_cnt_out[0]` pulses. Without the macro, the same packet is forwarded.
- Stop sequence:
  - Set `hssl_stop_in` with a packet buffered and `pkt_rdy_in=0`: state holds FLUSH.
  - Raise `pkt_rdy_in`: buffer drains and state goes to STOP.
  - Send a data packet: dropped, `ctr_cnt_out[0]` pulses.
  - Send a configuration packet: still written.
  - Clear `hssl_stop_in`: state returns to RUN.
- Reset asserted while `pkt_vld_out=1`: next cycle all outputs are zero and state is RUN.
